// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard interrupt scheduler.
package kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT_ACK} states_t;

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam int         ENTRY_W    = 9;
endpackage

// File: rtl/kbd_intr_sched_if.sv
// Keyboard-side strobes in, MCU-side interrupt and presented code out.
interface kbd_intr_sched_if #(
  parameter int DEPTH = 8
);
  import kbd_pkg::*;

  localparam int CODE_W = ENTRY_W - 1;

  logic                     code_valid;
  logic [CODE_W-1:0]        code_in;
  logic                     ack;
  logic                     clr_ovf;
  logic                     intrpt;
  logic [CODE_W-1:0]        scancode;
  logic                     ext;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output code_valid, code_in, ack, clr_ovf,
    input  intrpt, scancode, ext, overflow, count
  );

  modport slave (
    input  code_valid, code_in, ack, clr_ovf,
    output intrpt, scancode, ext, overflow, count
  );
endinterface

// File: rtl/kbd_fifo.sv
// Synchronous FIFO with a combinational head read; pointers wrap modulo DEPTH.
module kbd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/kbd_intr_sched.sv
// Buffers scancodes, folds the E0 prefix into an EXT flag, and raises one
// interrupt pulse per buffered event until the MCU acknowledges it.
module kbd_intr_sched
  import kbd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PULSE_LEN    = 9,
  parameter int RETRY_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  kbd_intr_sched_if.slave   bus
);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int RW = (RETRY_CYCLES > 0) ? $clog2(RETRY_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'((RETRY_CYCLES > 0) ? RETRY_CYCLES - 1 : 0);

  states_t              state_q, state_d;
  logic                 intrpt_q, intrpt_d;
  logic [7:0]           scancode_q, scancode_d;
  logic                 ext_q, ext_d;
  logic                 ext_pending_q, ext_pending_d;
  logic                 overflow_q, overflow_d;
  logic                 ack_seen_q, ack_seen_d;
  logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [RW-1:0]        retry_cnt_q, retry_cnt_d;

  logic                 is_prefix, wr_code, push, pop;
  logic                 fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  kbd_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({ext_pending_q, bus.code_in}),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Prefix absorption and drop accounting; a dropped code still consumes ext_pending.
  always_comb begin
    is_prefix     = bus.code_valid && (bus.code_in == EXT_PREFIX);
    wr_code       = bus.code_valid && !is_prefix;
    push          = wr_code && (!fifo_full || pop);
    ext_pending_d = bus.code_valid ? is_prefix : ext_pending_q;
    if (wr_code && !push)  overflow_d = 1'b1;
    else if (bus.clr_ovf)  overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  always_comb begin
    state_d     = state_q;
    intrpt_d    = intrpt_q;
    scancode_d  = scancode_q;
    ext_d       = ext_q;
    ack_seen_d  = ack_seen_q;
    pulse_cnt_d = pulse_cnt_q;
    retry_cnt_d = retry_cnt_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d     = ST_PULSE;
          intrpt_d    = 1'b1;
          scancode_d  = fifo_head[7:0];
          ext_d       = fifo_head[8];
          pulse_cnt_d = '0;
          ack_seen_d  = 1'b0;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          intrpt_d = 1'b0;
          // An ACK on the final pulse cycle counts the same as an earlier one.
          if (ack_seen_q || bus.ack) begin
            pop        = 1'b1;
            ack_seen_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            retry_cnt_d = '0;
            state_d     = ST_WAIT_ACK;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
          if (bus.ack) ack_seen_d = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.ack) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if ((RETRY_CYCLES > 0) && (retry_cnt_q == RETRY_LAST)) begin
          state_d     = ST_PULSE;
          intrpt_d    = 1'b1;
          pulse_cnt_d = '0;
        end else begin
          retry_cnt_d = retry_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        intrpt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      intrpt_q      <= 1'b0;
      scancode_q    <= '0;
      ext_q         <= 1'b0;
      ext_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      ack_seen_q    <= 1'b0;
      pulse_cnt_q   <= '0;
      retry_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      intrpt_q      <= intrpt_d;
      scancode_q    <= scancode_d;
      ext_q         <= ext_d;
      ext_pending_q <= ext_pending_d;
      overflow_q    <= overflow_d;
      ack_seen_q    <= ack_seen_d;
      pulse_cnt_q   <= pulse_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
    end
  end

  assign bus.intrpt   = intrpt_q;
  assign bus.scancode = scancode_q;
  assign bus.ext      = ext_q;
  assign bus.overflow = overflow_q;
  assign bus.count    = fifo_count;
endmodule
